regfile_mp: RTL and testbench

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_mp.sv | 80 ++++++++
 tb/tb_regfile_mp.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// regfile_mp: multi-read-port register file with zero-sweep clear, optional r0 hardwiring and write bypass.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic [NUM_RD-1:0]          rd_en,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_valid,
  input  logic                       clr_req,
  output logic                       busy
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_CLEAR = 1'b1;
  logic [0:0]               state_q, state_d;
  logic [ADDR_W-1:0]        clr_cnt_q, clr_cnt_d;
  logic [DATA_W-1:0]        mem_q [DEPTH];
  logic [NUM_RD*DATA_W-1:0] rd_data_q, rd_data_d;
  logic [NUM_RD-1:0]        rd_valid_q, rd_valid_d;
  logic                     wr_eff;
  logic [ADDR_W-1:0]        a;
  assign busy     = state_q == S_CLEAR;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  // clear request beats a same-cycle write; r0 writes vanish when hardwired
  assign wr_eff = !busy && !clr_req && wr_en && !(ZERO_REG != 0 && wr_addr == '0);
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (busy) begin
      clr_cnt_d = clr_cnt_q + 1'b1;
      state_d   = clr_cnt_q == ADDR_W'(DEPTH - 1) ? S_IDLE : S_CLEAR;
    end else if (clr_req) begin
      state_d   = S_CLEAR;
      clr_cnt_d = '0;
    end
  end
  always_comb begin
    rd_data_d  = rd_data_q;
    rd_valid_d = '0;
    a          = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      a = rd_addr[p*ADDR_W +: ADDR_W];
      if (rd_en[p] && !busy) begin
        rd_valid_d[p] = 1'b1;
        rd_data_d[p*DATA_W +: DATA_W] =
          (ZERO_REG != 0 && a == '0)             ? '0 :
          (BYPASS != 0 && wr_eff && a == wr_addr) ? wr_data :
                                                    mem_q[a];
      end
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_CLEAR;
      clr_cnt_q  <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end
  // array has no reset; the sweep zeroes it one entry per edge
  always_ff @(posedge clk) begin
    if (busy) mem_q[clr_cnt_q] <= '0;
    else if (wr_eff) mem_q[wr_addr] <= wr_data;
  end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed and random stimulus against an array-based reference model.
module tb_regfile_mp;
  localparam int DW = 32, AW = 5, NR = 2, DEPTH = 32;
  logic clk = 0, rst = 0, wr_en = 0, clr_req = 0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic [NR-1:0] rd_en = '0;
  logic [NR*AW-1:0] rd_addr = '0;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0] rd_valid;
  logic busy;
  int checks = 0, failures = 0;
  logic [DW-1:0] mem_m [DEPTH];
  bit busy_m;
  int clr_idx;
  logic [DW-1:0] rdd_m [NR];
  bit rdv_m [NR];

  regfile_mp dut (.clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .clr_req(clr_req), .busy(busy));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'(busy_m));
    for (int p = 0; p < NR; p++) begin
      check($sformatf("%s_valid%0d", tag, p), 64'(rd_valid[p]), 64'(rdv_m[p]));
      check($sformatf("%s_data%0d", tag, p), 64'(rd_data[p*DW +: DW]), 64'(rdd_m[p]));
    end
  endtask

  task automatic model_reset();
    busy_m = 1;
    clr_idx = 0;
    for (int p = 0; p < NR; p++) begin rdd_m[p] = '0; rdv_m[p] = 0; end
  endtask

  task automatic model_edge();
    bit wr_ok;
    logic [AW-1:0] ra;
    wr_ok = !busy_m && wr_en && !clr_req && wr_addr != 0;
    for (int p = 0; p < NR; p++) begin
      ra = rd_addr[p*AW +: AW];
      rdv_m[p] = !busy_m && rd_en[p];
      if (rdv_m[p]) rdd_m[p] = ra == 0 ? '0 : (wr_ok && ra == wr_addr) ? wr_data : mem_m[ra];
    end
    if (busy_m) begin
      mem_m[clr_idx] = '0;
      clr_idx++;
      if (clr_idx == DEPTH) begin busy_m = 0; clr_idx = 0; end
    end else if (clr_req) begin
      busy_m = 1;
      clr_idx = 0;
    end else if (wr_ok) mem_m[wr_addr] = wr_data;
  endtask

  task automatic cycle(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  task automatic set_rd(input logic [NR-1:0] en, input int a0, input int a1);
    rd_en = en;
    rd_addr = {AW'(a1), AW'(a0)};
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    rst = 1;
    for (int i = 0; i < DEPTH; i++) cycle("sweep");
    check("busy_after_sweep", 64'(busy), 64'(0));
    for (int a = 0; a < DEPTH; a++) begin
      set_rd(2'b11, a, DEPTH - 1 - a);
      cycle("read_zero");
    end
    set_rd(2'b00, 0, 0);
    wr_en = 1; wr_addr = 1; wr_data = 32'hA5A5A5A5;
    cycle("wr1");
    wr_addr = 2; wr_data = 32'h5A5A5A5A;
    cycle("wr2");
    wr_en = 0;
    set_rd(2'b11, 1, 2);
    cycle("rd12");
    check("rd1_const", 64'(rd_data[DW-1:0]), 64'h00000000A5A5A5A5);
    check("rd2_const", 64'(rd_data[2*DW-1:DW]), 64'h000000005A5A5A5A);
    wr_en = 1; wr_addr = 7; wr_data = 32'hDEADBEEF;
    set_rd(2'b01, 7, 0);
    cycle("bypass");
    check("bypass_const", 64'(rd_data[DW-1:0]), 64'h00000000DEADBEEF);
    wr_addr = 0; wr_data = 32'hFFFFFFFF;
    set_rd(2'b00, 0, 0);
    cycle("wr0");
    wr_en = 0;
    set_rd(2'b11, 0, 0);
    cycle("rd0");
    check("rd0_const", 64'(rd_data), 64'(0));
    wr_en = 1; wr_addr = 3; wr_data = 32'h12345678;
    cycle("wr3");
    clr_req = 1; wr_data = 32'h87654321;
    set_rd(2'b11, 3, 3);
    cycle("clr_start");
    check("clr_busy", 64'(busy), 64'(1));
    for (int i = 0; i < DEPTH; i++) begin
      clr_req = i[0];
      wr_en = 1; wr_addr = AW'(i); wr_data = $urandom;
      cycle("clr_sweep");
    end
    clr_req = 0; wr_en = 0;
    set_rd(2'b11, 3, 7);
    cycle("rd3_after_clr");
    check("rd3_zero", 64'(rd_data[DW-1:0]), 64'(0));
    set_rd(2'b00, 0, 0);
    clr_req = 1;
    cycle("clr2_start");
    clr_req = 0;
    for (int i = 0; i < 10; i++) cycle("pre_rst");
    #2;
    rst = 0;
    model_reset();
    #1;
    check_outputs("mid_rst");
    @(posedge clk);
    #1;
    check_outputs("mid_rst_edge");
    rst = 1;
    for (int i = 0; i < DEPTH; i++) begin
      check("resweep_busy", 64'(busy), 64'(1));
      set_rd(2'b11, i, i);
      cycle("resweep");
    end
    check("resweep_done", 64'(busy), 64'(0));
    for (int i = 0; i < 600; i++) begin
      wr_en = 1'($urandom);
      wr_addr = AW'($urandom_range(0, 7));
      wr_data = $urandom;
      set_rd(NR'($urandom), $urandom_range(0, 7), $urandom_range(0, 7));
      clr_req = $urandom_range(0, 63) == 0;
      cycle("rand");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
